// File: rtl/div_seq_if.sv
// Handshake and data bundle for the sequential divider.
// The master side issues operands and start; the slave side returns status and results.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_zero, lo, hi
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_zero, lo, hi
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider producing quotient (lo) and remainder (hi).
// Signed operands are reduced to magnitudes on entry, and the signs are restored in FIX.
// A zero divisor is reported through div_zero without starting the iteration.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_dv_zero;

  // Two's-complement negation when en is set, pass-through otherwise.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    neg_if = en ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Magnitude of x when interpreted as signed; the most negative value maps to itself as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    mag = neg_if(x, sgn & x[WIDTH-1]);
  endfunction

  assign w_dv_zero = (bus.divisor == {WIDTH{1'b0}});

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_dvs};
    if (!w_diff[WIDTH]) begin
      w_rem_nxt = w_diff[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_shift[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM together with the datapath and the registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
      r_rem   <= {WIDTH{1'b0}};
      r_quo   <= {WIDTH{1'b0}};
      r_dvs   <= {WIDTH{1'b0}};
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_lo    <= {WIDTH{1'b0}};
      r_hi    <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_dv_zero) begin
              r_dz   <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_quo   <= mag(bus.dividend, bus.is_signed);
              r_dvs   <= mag(bus.divisor, bus.is_signed);
              r_rem   <= {WIDTH{1'b0}};
              r_qsign <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              r_rsign <= bus.is_signed & bus.dividend[WIDTH-1];
              r_cnt   <= {CW{1'b0}};
              r_dz    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_cnt   <= {CW{1'b0}};
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          r_lo    <= neg_if(r_quo, r_qsign);
          r_hi    <= neg_if(r_rem, r_rsign);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;
  assign bus.lo       = r_lo;
  assign bus.hi       = r_hi;
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq at WIDTH=32 and WIDTH=8 with a scoreboard of expected results.
module tb_div_seq;
  logic clk;
  logic reset;
  int   cyc;
  int   n_pass;
  int   n_total;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  vec_t vecs[10];

  div_seq_if #(.WIDTH(32)) b32 ();
  div_seq_if #(.WIDTH(8))  b8 ();

  div_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  div_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to check latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic issue(input bit w8, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lo, input logic [31:0] hi, input logic dz);
    exp_t e;
    e.lo = lo; e.hi = hi; e.dz = dz;
    if (w8) begin
      b8.start = 1'b1; b8.is_signed = sgn; b8.dividend = a[7:0]; b8.divisor = b[7:0];
      e.cyc = cyc + (dz ? 1 : 10);
      q8.push_back(e);
    end else begin
      b32.start = 1'b1; b32.is_signed = sgn; b32.dividend = a; b32.divisor = b;
      e.cyc = cyc + (dz ? 1 : 34);
      q32.push_back(e);
    end
  endtask

  // Advance to the next falling edge and score any completed operation.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (b32.done) begin
      if (q32.size() == 0) check("w32_spurious_done", {31'd0, b32.done}, 32'd0);
      else begin
        e = q32.pop_front();
        check("w32_lo", b32.lo, e.lo);
        check("w32_hi", b32.hi, e.hi);
        check("w32_dz", {31'd0, b32.div_zero}, {31'd0, e.dz});
        check("w32_latency", cyc, e.cyc);
      end
    end
    if (b8.done) begin
      if (q8.size() == 0) check("w8_spurious_done", {31'd0, b8.done}, 32'd0);
      else begin
        e = q8.pop_front();
        check("w8_lo", {24'd0, b8.lo}, e.lo);
        check("w8_hi", {24'd0, b8.hi}, e.hi);
        check("w8_dz", {31'd0, b8.div_zero}, {31'd0, e.dz});
        check("w8_latency", cyc, e.cyc);
      end
    end
  endtask

  // Step until both scoreboards drain; counts falling edges with the 32-bit busy high.
  task automatic run_wait(output int bc);
    bc = 0;
    for (int k = 0; k < 200 && (q32.size() != 0 || q8.size() != 0); k++) begin
      step();
      b32.start = 1'b0;
      b8.start  = 1'b0;
      if (b32.busy) bc++;
    end
    check("timeout_w32", q32.size(), 32'd0);
    check("timeout_w8", q8.size(), 32'd0);
    q32.delete();
    q8.delete();
  endtask

  initial begin
    int bc;
    cyc = 0; n_pass = 0; n_total = 0;
    reset = 1'b0;
    b32.start = 1'b0; b32.is_signed = 1'b0; b32.dividend = 32'd0; b32.divisor = 32'd0;
    b8.start  = 1'b0; b8.is_signed  = 1'b0; b8.dividend  = 8'd0;  b8.divisor  = 8'd0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    vecs[7] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0};
    vecs[8] = '{1'b1, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[9] = '{1'b0, 32'd1_000_000,  32'd1_000,      32'd1_000,      32'd0,          1'b0};

    // Reset state
    step(); step();
    check("rst_busy", {31'd0, b32.busy}, 32'd0);
    check("rst_done", {31'd0, b32.done}, 32'd0);
    check("rst_dz",   {31'd0, b32.div_zero}, 32'd0);
    check("rst_lo",   b32.lo, 32'd0);
    check("rst_hi",   b32.hi, 32'd0);
    check("rst_lo8",  {24'd0, b8.lo}, 32'd0);
    reset = 1'b1;
    step();

    // Table-driven vectors at WIDTH=32
    for (int i = 0; i < 10; i++) begin
      issue(1'b0, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].dz);
      run_wait(bc);
    end

    // 100 / 7 with busy duration
    issue(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_wait(bc);
    check("busy_cycles", bc, 32'd33);

    // Divide by zero keeps lo/hi, flags, holds flag, busy stays low
    issue(1'b0, 1'b0, 32'd5, 32'd0, 32'd14, 32'd2, 1'b1);
    step();
    check("dz_busy", {31'd0, b32.busy}, 32'd0);
    b32.start = 1'b0;
    step(); step();
    check("dz_hold", {31'd0, b32.div_zero}, 32'd1);
    check("dz_single_done", {31'd0, b32.done}, 32'd0);
    check("dz_queue", q32.size(), 32'd0);
    issue(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    run_wait(bc);

    // start and operand changes mid-CALC are ignored
    issue(1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    step();
    b32.start = 1'b0;
    repeat (5) step();
    b32.start = 1'b1; b32.is_signed = 1'b1; b32.dividend = 32'd7; b32.divisor = 32'd0;
    step();
    b32.start = 1'b0;
    run_wait(bc);

    // start held through done: second op accepted in the done cycle
    issue(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    for (int k = 0; k < 60 && q32.size() != 0; k++) step();
    check("b2b_first_done", {31'd0, b32.done}, 32'd1);
    issue(1'b0, 1'b0, 32'd45, 32'd6, 32'd7, 32'd3, 1'b0);
    step();
    check("b2b_busy", {31'd0, b32.busy}, 32'd1);
    run_wait(bc);

    // Asynchronous reset at iteration 10 aborts the op
    b32.start = 1'b1; b32.is_signed = 1'b0; b32.dividend = 32'd1000; b32.divisor = 32'd3;
    step();
    b32.start = 1'b0;
    repeat (9) step();
    check("pre_rst_busy", {31'd0, b32.busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, b32.busy}, 32'd0);
    check("arst_done", {31'd0, b32.done}, 32'd0);
    check("arst_dz",   {31'd0, b32.div_zero}, 32'd0);
    check("arst_lo",   b32.lo, 32'd0);
    check("arst_hi",   b32.hi, 32'd0);
    repeat (3) step();
    reset = 1'b1;
    step();
    issue(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    run_wait(bc);

    // WIDTH=8 instance
    issue(1'b1, 1'b0, 32'd200, 32'd13, 32'd15, 32'd5, 1'b0);
    run_wait(bc);
    issue(1'b1, 1'b1, 32'h80, 32'hFF, 32'h80, 32'd0, 1'b0);
    run_wait(bc);
    issue(1'b1, 1'b1, 32'h9C, 32'd7, 32'hF2, 32'hFE, 1'b0);
    run_wait(bc);
    issue(1'b1, 1'b0, 32'd17, 32'd0, 32'hF2, 32'hFE, 1'b1);
    run_wait(bc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
